// File: rtl/pio_led_blinker_if.sv
// rtl/pio_led_blinker_if.sv - Avalon-MM slave bus bundle for the LED blinker PIO
//
// Purpose : groups the Avalon-MM register-access signals so the PIO and its
//           bus master connect through a single port.
// Signals : address    [2:0]  word address of the register
//           chipselect        slave select
//           write_n           active-low write strobe
//           writedata  [31:0] write data
//           readdata   [31:0] combinational read data (driven by the slave)
// Modports: master drives the request signals, slave drives readdata.

interface pio_led_blinker_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/pio_led_blinker.sv
// rtl/pio_led_blinker.sv - Avalon-MM LED output PIO with shared-period blink engine
//
// Purpose : drives WIDTH LED lines from a static DATA register; lines enabled
//           in BLINK are gated by a phase bit that toggles every PERIOD+1
//           cycles. Optional OUTSET/OUTCLEAR registers (macro
//           PIO_LED_BITSET_EN) allow atomic per-bit updates of DATA.
// Ports   : clk       single clock
//           reset     synchronous, active-high
//           bus       Avalon-MM slave (address, chipselect, write_n,
//                     writedata, readdata)
//           out_port  [WIDTH-1:0] LED drive
// Map     : 0 DATA, 1 BLINK, 2 PERIOD, 3 STATUS (bit0 = phase),
//           4 OUTSET, 5 OUTCLEAR (write-only, read 0), 6..7 reserved.

module pio_led_blinker #(
   parameter int                  WIDTH        = 10,
   parameter int                  PERIOD_W     = 24,
   parameter logic [PERIOD_W-1:0] PERIOD_RESET = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   pio_led_blinker_if.slave       bus,
   output logic [WIDTH-1:0]       out_port
);

   localparam logic [PERIOD_W-1:0] CNT_ONE = 1;

   logic [WIDTH-1:0]    data_q;
   logic [WIDTH-1:0]    blink_q;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] cnt_q;
   logic                phase_q;
   logic                wr;
   logic [31:0]         rd;

   // Bits of writedata above WIDTH/PERIOD_W are deliberately dropped.
   logic unused_writedata;
   assign unused_writedata = ^bus.writedata;

   assign wr = bus.chipselect && !bus.write_n;

   // Register file. The bus guarantees at most one register write per cycle,
   // so DATA/BLINK writes never collide with each other; the blink counter
   // runs independently of them.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q   <= '0;
         blink_q  <= '0;
         period_q <= PERIOD_RESET;
         cnt_q    <= '0;
         phase_q  <= 1'b1;
      end else begin
         if (wr) begin
            case (bus.address)
               3'd0: data_q  <= bus.writedata[WIDTH-1:0];
               3'd1: blink_q <= bus.writedata[WIDTH-1:0];
`ifdef PIO_LED_BITSET_EN
               3'd4: data_q  <= data_q | bus.writedata[WIDTH-1:0];
               3'd5: data_q  <= data_q & ~bus.writedata[WIDTH-1:0];
`endif
               default: ;
            endcase
         end

         // A PERIOD write restarts the engine in the "on" phase and wins over
         // a terminal-count toggle on the same edge.
         if (wr && bus.address == 3'd2) begin
            period_q <= bus.writedata[PERIOD_W-1:0];
            cnt_q    <= '0;
            phase_q  <= 1'b1;
         end else if (period_q == '0) begin
            // Frozen engine: blinking lines show DATA steadily.
            cnt_q   <= '0;
            phase_q <= 1'b1;
         end else if (cnt_q == period_q) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
         end else begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end
   end

   // Output comes straight from the registers so writes and phase toggles
   // are visible from the edge that updates them.
   assign out_port = data_q & (~blink_q | {WIDTH{phase_q}});

   // Combinational read path, not gated by chipselect.
   always_comb begin
      rd = '0;
      case (bus.address)
         3'd0: rd[WIDTH-1:0]    = data_q;
         3'd1: rd[WIDTH-1:0]    = blink_q;
         3'd2: rd[PERIOD_W-1:0] = period_q;
         3'd3: rd[0]            = phase_q;
         default: ;
      endcase
   end

   assign bus.readdata = rd;

endmodule

// File: tb/tb_pio_led_blinker.sv
// tb/tb_pio_led_blinker.sv - scoreboard testbench for pio_led_blinker
//
// Purpose : drives directed and random Avalon-MM traffic; a reference model
//           computes expected readdata/out_port, which a monitor compares at
//           every falling edge.
// Ports   : none (top-level bench).

module tb_pio_led_blinker;

   localparam int             WIDTH        = 10;
   localparam int             PERIOD_W     = 24;
   localparam logic [23:0]    PERIOD_RESET = 24'd0;

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] out_port;

   pio_led_blinker_if bus_if ();

   pio_led_blinker #(
      .WIDTH        (WIDTH),
      .PERIOD_W     (PERIOD_W),
      .PERIOD_RESET (PERIOD_RESET)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if),
      .out_port (out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]       addr;
      logic [31:0]      rd;
      logic [WIDTH-1:0] out;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: phase derived arithmetically from cycles elapsed since
   // the last restart point (reset or PERIOD write).
   bit               m_valid = 0;
   logic [WIDTH-1:0] m_data;
   logic [WIDTH-1:0] m_blink;
   logic [23:0]      m_period;
   longint           m_n;

   function automatic logic model_phase();
      if (m_period == 0) return 1'b1;
      return ((m_n / (longint'(m_period) + 1)) % 2) == 0;
   endfunction

   function automatic logic [WIDTH-1:0] model_out();
      logic [WIDTH-1:0] o;
      for (int i = 0; i < WIDTH; i++)
         o[i] = m_data[i] && (!m_blink[i] || model_phase());
      return o;
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return {22'd0, m_data};
         3'd1: return {22'd0, m_blink};
         3'd2: return {8'd0, m_period};
         3'd3: return {31'd0, model_phase()};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge(input logic rst, input logic cs, input logic wn,
                             input logic [2:0] a, input logic [31:0] wd);
      if (rst) begin
         m_data   = '0;
         m_blink  = '0;
         m_period = PERIOD_RESET;
         m_n      = 0;
         m_valid  = 1;
      end else if (m_valid) begin
         m_n++;
         if (cs && !wn) begin
            case (a)
               3'd0: m_data  = wd[WIDTH-1:0];
               3'd1: m_blink = wd[WIDTH-1:0];
               3'd2: begin m_period = wd[23:0]; m_n = 0; end
`ifdef PIO_LED_BITSET_EN
               3'd4: m_data = m_data | wd[WIDTH-1:0];
               3'd5: m_data = m_data & ~wd[WIDTH-1:0];
`endif
               default: ;
            endcase
         end
      end
   endtask

   // One bus cycle: drive inputs, queue expectation for this cycle, then
   // advance the model across the edge.
   task automatic cycle(input logic rst, input logic cs, input logic wn,
                        input logic [2:0] a, input logic [31:0] wd);
      exp_t e;
      reset               = rst;
      bus_if.chipselect   = cs;
      bus_if.write_n      = wn;
      bus_if.address      = a;
      bus_if.writedata    = wd;
      if (m_valid) begin
         e.addr = a;
         e.rd   = model_read(a);
         e.out  = model_out();
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      model_edge(rst, cs, wn, a, wd);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] wd);
      cycle(1'b0, 1'b1, 1'b0, a, wd);
   endtask

   task automatic rd(input logic [2:0] a);
      cycle(1'b0, 1'b1, 1'b1, a, 32'd0);
   endtask

   // Monitor: compares DUT outputs against queued expectations.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (bus_if.readdata !== e.rd) begin
               miscompares++;
               $display("FAIL readdata addr=%0d actual=%h required=%h t=%0t",
                        e.addr, bus_if.readdata, e.rd, $time);
            end
            vectors++;
            if (out_port !== e.out) begin
               miscompares++;
               $display("FAIL out_port actual=%h required=%h t=%0t",
                        out_port, e.out, $time);
            end
         end
      end
   end

   initial begin
      logic        r_rst, r_cs, r_wn;
      logic [2:0]  r_a;
      logic [31:0] r_wd;
      int          waited;

      // Reset then read back reset values.
      cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
      cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
      for (int i = 0; i < 4; i++) rd(3'(i));

      // Static write.
      wr(3'd0, 32'h0000_02A5);
      rd(3'd0);

      // Blink timing.
      wr(3'd0, 32'h0000_03FF);
      wr(3'd1, 32'h0000_000F);
      wr(3'd2, 32'd3);
      for (int i = 0; i < 16; i++) rd(3'd3);

      // PERIOD rewrite on the terminal-count cycle, then freeze.
      wr(3'd2, 32'd3);
      for (int i = 0; i < 3; i++) rd(3'd3);
      wr(3'd2, 32'd3);
      for (int i = 0; i < 6; i++) rd(3'd3);
      wr(3'd2, 32'd0);
      for (int i = 0; i < 6; i++) rd(3'd3);

      // Bit set / clear (ignored without the macro).
      wr(3'd0, 32'h0000_000F);
      wr(3'd4, 32'h0000_0300);
      rd(3'd0);
      wr(3'd5, 32'h0000_0003);
      rd(3'd0);
      rd(3'd4);
      rd(3'd5);

      // Reset mid-blink with a colliding write.
      wr(3'd2, 32'd2);
      wr(3'd1, 32'h0000_0155);
      wr(3'd0, 32'h0000_03FF);
      for (int i = 0; i < 4; i++) rd(3'd3);
      cycle(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0123);
      for (int i = 0; i < 4; i++) rd(3'(i));

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         r_rst = ($urandom_range(0, 199) == 0);
         r_cs  = ($urandom_range(0, 3) != 0);
         r_wn  = 1'($urandom_range(0, 1));
         r_a   = 3'($urandom_range(0, 7));
         r_wd  = $urandom;
         if (r_a == 3'd2 && $urandom_range(0, 15) != 0)
            r_wd = $urandom_range(0, 6);
         cycle(r_rst, r_cs, r_wn, r_a, r_wd);
      end
      rd(3'd0);

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      #1;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
